// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// pc_sequencer_pkg : shared state codes, redirect kinds and sign-extend helpers
// Revision: 1.0
// ============================================================================
package pc_sequencer_pkg;

    localparam logic [31:0] PC_INC_DEFAULT = 32'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_HOLD    = 3'd2,
        ST_RESOLVE = 3'd3,
        ST_HALTED  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        RES_KIND_IMM16 = 2'b00,
        RES_KIND_IMM26 = 2'b01,
        RES_KIND_REG   = 2'b10,
        RES_KIND_RSVD  = 2'b11
    } res_kind_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] sext26(input logic [25:0] v);
        return {{6{v[25]}}, v};
    endfunction

endpackage : pc_sequencer_pkg
`default_nettype wire

// File: rtl/pc_sequencer_target_calc.sv
`default_nettype none
// ============================================================================
// pc_target_calc : combinational sequential-PC adder and redirect target select
// Revision: 1.0
// ============================================================================
module pc_target_calc
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] PC_INC = PC_INC_DEFAULT
) (
    input  logic [31:0] instr_pc,
    input  res_kind_t   kind,
    input  logic [25:0] imm,
    input  logic [31:0] reg_target,
    output logic [31:0] seq_pc,
    output logic [31:0] target,
    output logic        misaligned
);

    assign seq_pc = instr_pc + PC_INC;

    // Offsets are byte offsets relative to the sequential PC; the add wraps mod 2^32.
    always_comb begin
        target     = seq_pc;
        misaligned = 1'b0;
        unique case (kind)
            RES_KIND_IMM16: target = seq_pc + sext16(imm[15:0]);
            RES_KIND_IMM26: target = seq_pc + sext26(imm);
            RES_KIND_REG:   target = reg_target;
            default:        misaligned = 1'b1;
        endcase
        if (target[1:0] != 2'b00) begin
            misaligned = 1'b1;
        end
    end

endmodule : pc_target_calc
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// pc_sequencer : multi-cycle fetch / hand-off / resolve next-PC controller
// Revision: 1.0   (bit 0 is the LSB on every vector; imm16 is res_imm[15:0])
// ============================================================================
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = PC_INC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] link_addr,
    input  logic        res_valid,
    input  logic        res_taken,
    input  logic [1:0]  res_kind,
    input  logic [25:0] res_imm,
    input  logic [31:0] res_reg,
    input  logic        res_halt,
    output logic        halted,
    output logic        align_err
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        imem_req_q, imem_req_d;
    logic        instr_valid_q, instr_valid_d;
    logic        halted_q, halted_d;
    logic        align_err_q, align_err_d;

    logic [31:0] w_seq_pc;
    logic [31:0] w_target;
    logic        w_misaligned;

    pc_target_calc #(
        .PC_INC (PC_INC)
    ) u_target_calc (
        .instr_pc   (instr_pc_q),
        .kind       (res_kind_t'(res_kind)),
        .imm        (res_imm),
        .reg_target (res_reg),
        .seq_pc     (w_seq_pc),
        .target     (w_target),
        .misaligned (w_misaligned)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        imem_req_d    = imem_req_q;
        instr_valid_d = instr_valid_q;
        halted_d      = halted_q;
        align_err_d   = align_err_q;
        unique case (state_q)
            ST_IDLE: begin
                state_d    = ST_FETCH;
                imem_req_d = 1'b1;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_d       = imem_data;
                    instr_pc_d    = pc_q;
                    imem_req_d    = 1'b0;
                    instr_valid_d = 1'b1;
                    state_d       = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (instr_ready) begin
                    instr_valid_d = 1'b0;
                    state_d       = ST_RESOLVE;
                end
            end
            ST_RESOLVE: begin
                // Halt outranks a redirect; a bad target stops the core rather than fetching.
                if (res_valid) begin
                    if (res_halt) begin
                        halted_d = 1'b1;
                        state_d  = ST_HALTED;
                    end else if (!res_taken) begin
                        pc_d       = w_seq_pc;
                        imem_req_d = 1'b1;
                        state_d    = ST_FETCH;
                    end else if (w_misaligned) begin
                        align_err_d = 1'b1;
                        halted_d    = 1'b1;
                        state_d     = ST_HALTED;
                    end else begin
                        pc_d       = w_target;
                        imem_req_d = 1'b1;
                        state_d    = ST_FETCH;
                    end
                end
            end
            ST_HALTED: begin
                imem_req_d    = 1'b0;
                instr_valid_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_pc_q    <= RESET_PC;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            align_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
            align_err_q   <= align_err_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign link_addr   = w_seq_pc;
    assign halted      = halted_q;
    assign align_err   = align_err_q;

endmodule : pc_sequencer
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// tb_pc_sequencer : directed stimulus with a transaction-level next-PC model
// Revision: 1.0
// ============================================================================
module tb_pc_sequencer;

    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_data = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] link_addr;
    logic        res_valid = 1'b0;
    logic        res_taken = 1'b0;
    logic [1:0]  res_kind = '0;
    logic [25:0] res_imm = '0;
    logic [31:0] res_reg = '0;
    logic        res_halt = 1'b0;
    logic        halted;
    logic        align_err;

    int checks = 0;
    int errors = 0;

    // Model state: what the next fetch address must be, and what the core must see.
    logic [31:0] exp_fetch_pc = C_RESET_PC;
    logic [31:0] exp_instr    = '0;
    logic [31:0] exp_instr_pc = C_RESET_PC;
    logic        exp_halted   = 1'b0;
    logic        exp_align    = 1'b0;

    pc_sequencer #(
        .RESET_PC (C_RESET_PC),
        .PC_INC   (32'd4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .link_addr   (link_addr),
        .res_valid   (res_valid),
        .res_taken   (res_taken),
        .res_kind    (res_kind),
        .res_imm     (res_imm),
        .res_reg     (res_reg),
        .res_halt    (res_halt),
        .halted      (halted),
        .align_err   (align_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_fetch_pc = C_RESET_PC;
        exp_instr    = '0;
        exp_instr_pc = C_RESET_PC;
        exp_halted   = 1'b0;
        exp_align    = 1'b0;
    endtask

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_imem_req", imem_req, 0);
            chk("rst_imem_addr", imem_addr, C_RESET_PC);
            chk("rst_instr_valid", instr_valid, 0);
            chk("rst_instr", instr, 0);
            chk("rst_instr_pc", instr_pc, C_RESET_PC);
            chk("rst_link_addr", link_addr, C_RESET_PC + 32'd4);
            chk("rst_halted", halted, 0);
            chk("rst_align_err", align_err, 0);
        end else begin
            chk("halted", halted, exp_halted);
            chk("align_err", align_err, exp_align);
            if (imem_req) chk("imem_addr", imem_addr, exp_fetch_pc);
            if (instr_valid) begin
                chk("instr", instr, exp_instr);
                chk("instr_pc", instr_pc, exp_instr_pc);
                chk("link_addr", link_addr, exp_instr_pc + 32'd4);
                chk("req_during_hold", imem_req, 0);
            end
            if (exp_halted) begin
                chk("req_when_halted", imem_req, 0);
                chk("valid_when_halted", instr_valid, 0);
            end
        end
    end

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!imem_req && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!imem_req) chk("req_timeout", imem_req, 1);
    endtask

    task automatic fetch(input logic [31:0] data, input int delay);
        wait_req();
        repeat (delay) begin @(posedge clk); #1; end
        imem_ack     = 1'b1;
        imem_data    = data;
        exp_instr    = data;
        exp_instr_pc = exp_fetch_pc;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        chk("valid_after_ack", instr_valid, 1);
    endtask

    task automatic accept(input int low_cycles);
        instr_ready = 1'b0;
        repeat (low_cycles) begin @(posedge clk); #1; end
        instr_ready = 1'b1;
        @(posedge clk); #1;
        instr_ready = 1'b0;
        chk("valid_drop_on_accept", instr_valid, 0);
    endtask

    task automatic resolve(input logic taken, input logic [1:0] kind, input logic [25:0] imm,
                           input logic [31:0] rreg, input logic halt, input int delay);
        logic [31:0] tgt;
        logic        bad;
        repeat (delay) begin @(posedge clk); #1; end
        res_valid = 1'b1; res_taken = taken; res_kind = kind;
        res_imm = imm; res_reg = rreg; res_halt = halt;
        @(posedge clk); #1;
        res_valid = 1'b0; res_taken = 1'b0; res_halt = 1'b0;
        bad = 1'b0;
        tgt = '0;
        if (halt) begin
            exp_halted = 1'b1;
        end else if (!taken) begin
            exp_fetch_pc = exp_instr_pc + 32'd4;
        end else begin
            case (kind)
                2'b00:   tgt = exp_instr_pc + 32'd4 + 32'($signed(imm[15:0]));
                2'b01:   tgt = exp_instr_pc + 32'd4 + 32'($signed(imm));
                2'b10:   tgt = rreg;
                default: bad = 1'b1;
            endcase
            if (bad || tgt[1:0] != 2'b00) begin
                exp_halted = 1'b1;
                exp_align  = 1'b1;
            end else begin
                exp_fetch_pc = tgt;
            end
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        // Reset release to first valid instruction, ack two cycles after req.
        model_reset();
        reset_n = 1'b1;
        chk("idle_no_req", imem_req, 0);
        @(posedge clk); #1;
        chk("first_req", imem_req, 1);
        chk("first_addr", imem_addr, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        imem_ack = 1'b1; imem_data = 32'h2001_0005;
        exp_instr = 32'h2001_0005; exp_instr_pc = 32'h0;
        chk("not_valid_at_ack", instr_valid, 0);
        @(posedge clk); #1;
        imem_ack = 1'b0;
        chk("valid_4_after_release", instr_valid, 1);
        chk("first_instr", instr, 32'h2001_0005);
        chk("first_instr_pc", instr_pc, 32'h0);
        accept(0);
        resolve(1'b1, 2'b10, 26'h0, 32'h0000_0100, 1'b0, 2);

        // Stall in HOLD with spurious ack and resolve strobes.
        fetch(32'h1111_2222, 0);
        imem_ack = 1'b1; imem_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        res_valid = 1'b1; res_taken = 1'b1; res_halt = 1'b1; res_kind = 2'b10; res_reg = 32'h40;
        @(posedge clk); #1;
        res_valid = 1'b0; res_taken = 1'b0; res_halt = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("hold_still_valid", instr_valid, 1);
        chk("hold_instr_stable", instr, 32'h1111_2222);
        chk("hold_no_req", imem_req, 0);
        accept(0);
        resolve(1'b0, 2'b00, 26'h0, 32'h0, 1'b0, 0);
        chk("not_taken_addr", imem_addr, 32'h0000_0104);

        fetch(32'h3333_4444, 1);
        accept(1);
        resolve(1'b1, 2'b10, 26'h0, 32'h0000_0100, 1'b0, 0);
        fetch(32'h5555_6666, 0);
        accept(0);
        resolve(1'b1, 2'b00, 26'h2A0_FFF8, 32'h0, 1'b0, 1);
        chk("imm16_back_addr", imem_addr, 32'h0000_00FC);

        fetch(32'h7777_8888, 0);
        accept(0);
        resolve(1'b1, 2'b10, 26'h0, 32'hFFFF_FFF0, 1'b0, 0);
        fetch(32'h9999_AAAA, 0);
        accept(0);
        chk("link_at_top", link_addr, 32'hFFFF_FFF4);
        resolve(1'b1, 2'b01, 26'h000_0010, 32'h0, 1'b0, 3);
        chk("imm26_wrap_addr", imem_addr, 32'h0000_0004);

        fetch(32'hBBBB_CCCC, 0);
        accept(0);
        resolve(1'b1, 2'b10, 26'h0, 32'h0000_0202, 1'b0, 0);
        chk("misalign_err", align_err, 1);
        chk("misalign_halt", halted, 1);
        repeat (5) begin @(posedge clk); #1; end
        chk("halt_no_req", imem_req, 0);

        // Reserved kind halts with align_err.
        do_reset();
        fetch(32'h0000_0011, 0);
        accept(0);
        resolve(1'b1, 2'b11, 26'h0, 32'h0, 1'b0, 0);
        chk("kind11_err", align_err, 1);
        chk("kind11_halt", halted, 1);

        // Negative imm26 loops back, then halt wins over taken.
        do_reset();
        fetch(32'h0000_0022, 0);
        accept(0);
        resolve(1'b1, 2'b01, 26'h3FF_FFFC, 32'h0, 1'b0, 0);
        chk("imm26_neg_addr", imem_addr, 32'h0);
        fetch(32'h0000_0033, 0);
        accept(0);
        resolve(1'b1, 2'b10, 26'h0, 32'h0000_0202, 1'b1, 0);
        chk("halt_prio_halted", halted, 1);
        chk("halt_prio_no_err", align_err, 0);

        // Reset during FETCH with a same-cycle ack.
        do_reset();
        wait_req();
        imem_ack = 1'b1; imem_data = 32'hFEED_F00D;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("async_req_drop", imem_req, 0);
        chk("async_valid", instr_valid, 0);
        chk("async_addr", imem_addr, C_RESET_PC);
        @(posedge clk); #1;
        chk("ack_dropped", instr, 32'h0);
        imem_ack = 1'b0;
        reset_n = 1'b1;
        fetch(32'h0BAD_CAFE, 1);
        chk("refetch_pc", instr_pc, C_RESET_PC);
        chk("refetch_instr", instr, 32'h0BAD_CAFE);
        accept(0);

        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL global_timeout actual=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule : tb_pc_sequencer
`default_nettype wire
